// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control-field bit positions and occupancy encodings for pipeline stage registers.
package pipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;
    localparam int WB_REGWR        = 0;
    localparam int WB_MEMTOREG_LSB = 1;
    localparam int WB_MEMTOREG_MSB = 2;
    localparam int WB_ADDRC_LSB    = 3;
    localparam int WB_ADDRC_MSB    = 7;
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream valid-ready handshake plus flush for one pipeline stage register.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_entry.sv
// pipe_entry: one valid+ctrl+data holding register; clear beats load, and data survives a clear.
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = clear_i ? 1'b0 : load_i ? 1'b1 : valid_q;
        ctrl_d  = clear_i ? '0 : load_i ? ctrl_i : ctrl_q;
        data_d  = (load_i & ~clear_i) ? data_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with flush and optional skid entry for registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter bit SKID   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    pipe_stage_reg_if.slave  bus,
    output logic [1:0]       occupancy
);
    logic              in_acc, out_acc;
    logic              m_valid, m_load, m_clear;
    logic              s_valid, s_load, s_clear, s_next;
    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
    logic [DATA_W-1:0] m_data, s_data, m_data_in;

    // Main refills from skid first so FIFO order holds when draining from TWO.
    always_comb begin
        in_acc     = bus.in_valid & bus.in_ready & ~bus.flush;
        out_acc    = m_valid & bus.out_ready & ~bus.flush;
        m_load     = (s_valid & out_acc) | (in_acc & (~m_valid | out_acc));
        m_clear    = bus.flush | (out_acc & ~m_load);
        s_load     = in_acc & m_valid & ~out_acc;
        s_clear    = bus.flush | (s_valid & out_acc);
        s_next     = s_load | (s_valid & ~s_clear);
        in_ready_d = ~s_next;
        m_ctrl_in  = s_valid ? s_ctrl : bus.in_ctrl;
        m_data_in  = s_valid ? s_data : bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) in_ready_q <= 1'b1;
        else       in_ready_q <= in_ready_d;
    end

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk, .reset, .load_i(m_load), .clear_i(m_clear),
        .ctrl_i(m_ctrl_in), .data_i(m_data_in),
        .valid_o(m_valid), .ctrl_o(m_ctrl), .data_o(m_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk, .reset, .load_i(s_load), .clear_i(s_clear),
                .ctrl_i(bus.in_ctrl), .data_i(bus.in_data),
                .valid_o(s_valid), .ctrl_o(s_ctrl), .data_o(s_data)
            );
        end else begin : g_noskid
            assign s_valid = 1'b0;
            assign s_ctrl  = '0;
            assign s_data  = '0;
        end
    endgenerate

    assign bus.in_ready  = SKID ? in_ready_q : (~m_valid | bus.out_ready);
    assign bus.out_valid = m_valid;
    assign bus.out_ctrl  = m_valid ? m_ctrl : '0;
    assign bus.out_data  = m_data;
    assign occupancy     = s_valid ? OCC_TWO : m_valid ? OCC_ONE : OCC_EMPTY;
endmodule
